// File: rtl/defuse_round_if.sv
// defuse_round_if: button/switch/LFSR inputs and screen/timer outputs of the round sequencer
interface defuse_round_if;
  logic       rand_btn;
  logic       set;
  logic [3:0] switch;
  logic       enable;
  logic       tick;
  logic [7:0] lfsr_val;
  logic       lfsr_step;
  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;
  logic [1:0] fourth;
  logic [1:0] main;
  logic [2:0] check;
  logic [7:0] period;
  logic [1:0] strikes;
  logic [2:0] status;
  modport master (
    output rand_btn, set, switch, enable, tick, lfsr_val,
    input  lfsr_step, first, second, third, fourth, main, check, period, strikes, status
  );
  modport slave (
    input  rand_btn, set, switch, enable, tick, lfsr_val,
    output lfsr_step, first, second, third, fourth, main, check, period, strikes, status
  );
endinterface

// File: rtl/defuse_round_ctrl.sv
// defuse_round_ctrl: bomb-defuse round sequencer (scramble, arm, countdown, grading, strikes)
module defuse_round_ctrl #(
  parameter logic [7:0] TIME_LIMIT  = 8'd60,
  parameter logic [1:0] MAX_STRIKES = 2'd3
) (
  input logic          clk,
  input logic          rst,
  defuse_round_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SHUFFLE, READY, ARMED, DEFUSED, EXPLODED} state_t;
  state_t     state, nxt;
  logic       rand_q, set_q, re, se, te, win;
  logic [1:0] first_n, second_n, third_n, fourth_n, main_n, idx, up;
  logic [7:0] period_n;
  logic [1:0] strikes_n;
  logic [3:0] key, eq;
  logic [2:0] chk;
  function automatic logic [3:0] key_of(input logic [1:0] a, b, c, d, m);
    return {a == m, b == m, c == m, d == m};
  endfunction
  always_comb begin
    re        = bus.enable & bus.rand_btn & ~rand_q;
    se        = bus.enable & bus.set & ~set_q;
    te        = bus.enable & bus.tick;
    idx       = bus.lfsr_val[5:4] ^ bus.lfsr_val[7:6];
    win       = bus.switch == key_of(bus.first, bus.second, bus.third, bus.fourth, bus.main);
    up        = (bus.strikes == MAX_STRIKES) ? MAX_STRIKES : bus.strikes + 2'd1;
    nxt       = state;
    first_n   = bus.first;
    second_n  = bus.second;
    third_n   = bus.third;
    fourth_n  = bus.fourth;
    main_n    = bus.main;
    period_n  = bus.period;
    strikes_n = bus.strikes;
    case (state)
      IDLE:    nxt = re ? SHUFFLE : IDLE;
      SHUFFLE: begin
        nxt       = READY;
        first_n   = bus.lfsr_val[1:0];
        second_n  = bus.lfsr_val[3:2];
        third_n   = bus.lfsr_val[5:4];
        fourth_n  = bus.lfsr_val[7:6];
        main_n    = idx == 2'd0 ? bus.lfsr_val[1:0] : idx == 2'd1 ? bus.lfsr_val[3:2] :
                    idx == 2'd2 ? bus.lfsr_val[5:4] : bus.lfsr_val[7:6];
        period_n  = TIME_LIMIT;
        strikes_n = 2'd0;
      end
      READY:   nxt = re ? SHUFFLE : se ? ARMED : READY;
      ARMED: begin
        if (se && win) nxt = DEFUSED;
        else begin
          strikes_n = se ? up : bus.strikes;
          period_n  = (te && bus.period != 8'd0) ? bus.period - 8'd1 : bus.period;
          if ((se && up == MAX_STRIKES) || (te && bus.period == 8'd1)) nxt = EXPLODED;
        end
      end
      DEFUSED, EXPLODED: nxt = re ? SHUFFLE : state;
      default: nxt = IDLE;
    endcase
    // grade against the screens that will be on display after this edge
    key = key_of(first_n, second_n, third_n, fourth_n, main_n);
    eq  = ~(bus.switch ^ key);
    chk = {2'b0, eq[0]} + {2'b0, eq[1]} + {2'b0, eq[2]} + {2'b0, eq[3]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rand_q        <= 1'b0;
      set_q         <= 1'b0;
      bus.lfsr_step <= 1'b0;
      bus.first     <= 2'd0;
      bus.second    <= 2'd0;
      bus.third     <= 2'd0;
      bus.fourth    <= 2'd0;
      bus.main      <= 2'd0;
      bus.check     <= 3'd0;
      bus.period    <= 8'd0;
      bus.strikes   <= 2'd0;
    end else begin
      state         <= nxt;
      rand_q        <= bus.rand_btn;
      set_q         <= bus.set;
      bus.lfsr_step <= nxt == SHUFFLE;
      bus.first     <= first_n;
      bus.second    <= second_n;
      bus.third     <= third_n;
      bus.fourth    <= fourth_n;
      bus.main      <= main_n;
      bus.period    <= period_n;
      bus.strikes   <= strikes_n;
      bus.check     <= !bus.enable ? bus.check : (nxt == READY || nxt == ARMED) ? chk : 3'd0;
    end
  end
  assign bus.status = state;
endmodule

// File: tb/tb_defuse_round_ctrl.sv
// tb_defuse_round_ctrl: directed scenarios with a queued-expectation scoreboard
module tb_defuse_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  defuse_round_if bus();
  defuse_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    int st, per, stk, ls, chk, scr;
  } exp_t;
  exp_t q[$];
  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic ex(string nm, int st, int per, int stk, int ls = 0, int chk = -1, int scr = -1);
    exp_t e;
    e = '{nm, st, per, stk, ls, chk, scr};
    q.push_back(e);
  endtask
  task automatic d(logic r, logic s, logic t, logic [3:0] sw);
    @(negedge clk);
    bus.rand_btn = r;
    bus.set      = s;
    bus.tick     = t;
    bus.switch   = sw;
  endtask
  task automatic rchk(string nm);
    cmp({nm, ".status"}, 32'(bus.status), 0);
    cmp({nm, ".period"}, 32'(bus.period), 0);
    cmp({nm, ".others"}, 32'({bus.first, bus.second, bus.third, bus.fourth, bus.main,
                              bus.check, bus.strikes, bus.lfsr_step}), 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp({e.nm, ".status"}, 32'(bus.status), e.st);
        cmp({e.nm, ".period"}, 32'(bus.period), e.per);
        cmp({e.nm, ".strikes"}, 32'(bus.strikes), e.stk);
        cmp({e.nm, ".lfsr_step"}, 32'(bus.lfsr_step), e.ls);
        if (e.chk >= 0) cmp({e.nm, ".check"}, 32'(bus.check), e.chk);
        if (e.scr >= 0)
          cmp({e.nm, ".screens"}, 32'({bus.first, bus.second, bus.third, bus.fourth, bus.main}), e.scr);
      end
    end
  end
  initial begin
    bus.rand_btn = 0; bus.set = 0; bus.tick = 0; bus.switch = 0;
    bus.enable = 1; bus.lfsr_val = 8'hB4;
    #12;
    rchk("reset");
    @(negedge clk);
    rst = 0;
    // B4: screens 00 01 11 10, target index 1 -> main 01, key 0100
    d(1, 0, 0, 0);            ex("shuffle", 1, 0, 0, 1);
    d(0, 0, 0, 0);            ex("ready", 2, 60, 0, 0, 3, 10'b00_01_11_10_01);
    d(0, 1, 0, 0);            ex("arm", 3, 60, 0);
    for (int i = 0; i < 5; i++) begin
      d(0, 0, 1, 0);          ex("tick", 3, 59 - i, 0);
    end
    d(0, 0, 0, 4'b0100);      ex("key", 3, 55, 0, 0, 4);
    d(0, 1, 0, 4'b0100);      ex("defuse", 4, 55, 0, 0, 0);
    d(0, 0, 1, 4'b0100);      ex("defhold", 4, 55, 0);
    // 6C: screens 00 11 10 01, index 3 -> main 01, key 0001
    bus.lfsr_val = 8'h6C;
    d(1, 0, 1, 0);            ex("reshuffle", 1, 55, 0, 1);
    d(0, 0, 0, 0);            ex("ready2", 2, 60, 0, 0, 3, 10'b00_11_10_01_01);
    d(0, 1, 0, 0);            ex("arm2", 3, 60, 0);
    d(0, 0, 0, 0);            ex("arm2b", 3, 60, 0, 0, 3);
    d(0, 1, 1, 0);            ex("strike1", 3, 59, 1);
    d(0, 0, 0, 0);            ex("s1hold", 3, 59, 1);
    d(0, 1, 0, 0);            ex("strike2", 3, 59, 2);
    d(0, 0, 0, 0);            ex("s2hold", 3, 59, 2);
    d(0, 1, 0, 0);            ex("boom", 5, 59, 3, 0, 0);
    d(0, 0, 1, 0);            ex("exphold", 5, 59, 3);
    d(0, 1, 0, 0);            ex("expset", 5, 59, 3);
    // E4: screens 00 01 10 11, index 1 -> main 01, key 0100
    bus.lfsr_val = 8'hE4;
    d(1, 0, 0, 0);            ex("sh3", 1, 59, 3, 1);
    d(0, 0, 0, 0);            ex("ready3", 2, 60, 0, 0, 3, 10'b00_01_10_11_01);
    d(0, 1, 0, 0);            ex("arm3", 3, 60, 0);
    for (int i = 0; i < 60; i++) begin
      d(0, 0, 1, 0);          ex("timeout", i == 59 ? 5 : 3, 59 - i, 0);
    end
    d(0, 0, 1, 0);            ex("tmohold", 5, 0, 0);
    d(1, 0, 0, 0);            ex("sh4", 1, 0, 0, 1);
    d(0, 0, 0, 0);            ex("ready4", 2, 60, 0);
    d(0, 1, 0, 0);            ex("arm4", 3, 60, 0);
    for (int i = 0; i < 59; i++) begin
      d(0, 0, 1, 0);          ex("count4", 3, 59 - i, 0);
    end
    d(0, 1, 1, 4'b0100);      ex("simul", 4, 1, 0);
    d(0, 0, 0, 0);            ex("simhold", 4, 1, 0);
    d(1, 0, 0, 0);            ex("sh5", 1, 1, 0, 1);
    d(0, 0, 0, 0);            ex("ready5", 2, 60, 0);
    d(0, 1, 0, 0);            ex("arm5", 3, 60, 0);
    d(0, 0, 0, 0);            ex("arm5b", 3, 60, 0);
    for (int i = 0; i < 10; i++) begin
      d(0, i == 4, 1, 0);
      bus.enable = 0;         ex("frozen", 3, 60, 0);
    end
    d(0, 1, 0, 0);            ex("setoff", 3, 60, 0);
    d(0, 1, 0, 0);
    bus.enable = 1;           ex("held", 3, 60, 0);
    d(0, 0, 0, 0);            ex("release", 3, 60, 0);
    d(0, 0, 1, 0);            ex("tick5", 3, 59, 0);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    rchk("arst");
    @(negedge clk);
    rst = 0;
    d(1, 0, 0, 0);            ex("sh6", 1, 0, 0, 1);
    d(0, 0, 0, 0);            ex("ready6", 2, 60, 0, 0, 3, 10'b00_01_10_11_01);
    repeat (2) @(posedge clk);
    #5;
    if (q.size() != 0) cmp("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
